// File: rtl/guess_entry.sv
// Guess entry front end: synchronizes SW and the confirm button, debounces the button,
// validates the BCD digits and offers accepted guesses over valid/ready.
// Define GUESS_DISTINCT_CHECK_EN to additionally reject entries with repeated digits.
module guess_entry #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        confirma,
    input  logic [15:0] SW,
    input  logic        guess_ready,
    output logic        guess_valid,
    output logic [15:0] guess,
    output logic        guess_error,
    output logic        busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        OFFER
    } state_t;

    logic             btn_meta_q, btn_meta_d;
    logic             btn_sync_q, btn_sync_d;
    logic [15:0]      sw_meta_q, sw_meta_d;
    logic [15:0]      sw_sync_q, sw_sync_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             deb_level_q, deb_level_d;
    logic             deb_level_d1_q, deb_level_d1_d;
    state_t           state_q, state_d;
    logic [15:0]      cap_q, cap_d;
    logic [15:0]      guess_q, guess_d;
    logic             guess_error_q, guess_error_d;
    logic             press;

    function automatic logic entry_ok(input logic [15:0] e);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (e[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
`ifdef GUESS_DISTINCT_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (e[i*4 +: 4] == e[j*4 +: 4]) ok = 1'b0;
            end
        end
`endif
        return ok;
    endfunction

    // Debounce: the level only follows the button after DEBOUNCE_CYCLES differing samples in a row.
    always_comb begin
        btn_meta_d     = confirma;
        btn_sync_d     = btn_meta_q;
        sw_meta_d      = SW;
        sw_sync_d      = sw_meta_q;
        deb_cnt_d      = '0;
        deb_level_d    = deb_level_q;
        deb_level_d1_d = deb_level_q;
        if (btn_sync_q != deb_level_q) begin
            if (deb_cnt_q == CNT_MAX) begin
                deb_level_d = ~deb_level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + CNT_W'(1);
            end
        end
    end

    assign press = deb_level_q & ~deb_level_d1_q;

    // Presses outside IDLE fall through untouched, so they are dropped rather than queued.
    always_comb begin
        state_d       = state_q;
        cap_d         = cap_q;
        guess_d       = guess_q;
        guess_error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (press) begin
                    cap_d   = sw_sync_q;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (entry_ok(cap_q)) begin
                    guess_d = cap_q;
                    state_d = OFFER;
                end else begin
                    guess_error_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            OFFER: begin
                if (guess_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_meta_q     <= 1'b0;
            btn_sync_q     <= 1'b0;
            sw_meta_q      <= '0;
            sw_sync_q      <= '0;
            deb_cnt_q      <= '0;
            deb_level_q    <= 1'b0;
            deb_level_d1_q <= 1'b0;
            state_q        <= IDLE;
            cap_q          <= '0;
            guess_q        <= '0;
            guess_error_q  <= 1'b0;
        end else begin
            btn_meta_q     <= btn_meta_d;
            btn_sync_q     <= btn_sync_d;
            sw_meta_q      <= sw_meta_d;
            sw_sync_q      <= sw_sync_d;
            deb_cnt_q      <= deb_cnt_d;
            deb_level_q    <= deb_level_d;
            deb_level_d1_q <= deb_level_d1_d;
            state_q        <= state_d;
            cap_q          <= cap_d;
            guess_q        <= guess_d;
            guess_error_q  <= guess_error_d;
        end
    end

    assign guess_valid = (state_q == OFFER);
    assign busy        = (state_q != IDLE);
    assign guess       = guess_q;
    assign guess_error = guess_error_q;

endmodule

// File: tb/tb_guess_entry.sv
// Self-checking bench for guess_entry with DEBOUNCE_CYCLES=4: directed vector table,
// hand-written timing/backpressure/bounce/reset sequences and a randomized phase.
module tb_guess_entry;

    localparam int D = 4;
`ifdef GUESS_DISTINCT_CHECK_EN
    localparam bit DISTINCT = 1'b1;
`else
    localparam bit DISTINCT = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        confirma = 1'b0;
    logic [15:0] SW = 16'h0;
    logic        guess_ready = 1'b0;
    logic        guess_valid;
    logic [15:0] guess;
    logic        guess_error;
    logic        busy;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    guess_entry #(.DEBOUNCE_CYCLES(D)) dut (
        .clock      (clock),
        .reset      (reset),
        .confirma   (confirma),
        .SW         (SW),
        .guess_ready(guess_ready),
        .guess_valid(guess_valid),
        .guess      (guess),
        .guess_error(guess_error),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Reference model state, expressed in terms of observed samples and pending work.
    bit          btn_hist[$];
    logic [15:0] sw_hist[$];
    bit          win[$];
    bit          m_level, m_level_old, m_valid, m_error, m_pending;
    logic [15:0] m_guess, m_cap;

    function automatic bit entry_ok_ref(input logic [15:0] e);
        int seen[16];
        int d;
        foreach (seen[k]) seen[k] = 0;
        for (int i = 0; i < 4; i++) begin
            d = int'((e >> (4 * i)) & 16'hF);
            if (d > 9) return 1'b0;
            seen[d]++;
        end
`ifdef GUESS_DISTINCT_CHECK_EN
        foreach (seen[k]) if (seen[k] > 1) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic model_step();
        bit syn_btn, press, all_diff;
        logic [15:0] syn_sw;
        if (reset) begin
            btn_hist.delete(); sw_hist.delete(); win.delete();
            m_level = 0; m_level_old = 0; m_valid = 0; m_error = 0; m_pending = 0;
            m_guess = 16'h0; m_cap = 16'h0;
            return;
        end
        btn_hist.push_back(confirma);
        sw_hist.push_back(SW);
        if (btn_hist.size() > 3) begin
            void'(btn_hist.pop_front());
            void'(sw_hist.pop_front());
        end
        syn_btn = (btn_hist.size() == 3) ? btn_hist[0] : 1'b0;
        syn_sw  = (sw_hist.size() == 3) ? sw_hist[0] : 16'h0;
        press = m_level && !m_level_old;
        win.push_back(syn_btn);
        if (win.size() > D) void'(win.pop_front());
        all_diff = (win.size() == D);
        foreach (win[k]) if (win[k] == m_level) all_diff = 0;
        m_level_old = m_level;
        if (all_diff) m_level = !m_level;
        m_error = 0;
        if (m_valid) begin
            if (guess_ready) m_valid = 0;
        end else if (m_pending) begin
            m_pending = 0;
            if (entry_ok_ref(m_cap)) begin
                m_valid = 1;
                m_guess = m_cap;
            end else begin
                m_error = 1;
            end
        end else if (press) begin
            m_pending = 1;
            m_cap = syn_sw;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        cyc++;
        #1;
        check("model", 32'({guess_valid, guess_error, busy, guess}),
              32'({m_valid, m_error, m_valid | m_pending, m_guess}));
    endtask

    function automatic logic [15:0] rand_entry();
        logic [15:0] e;
        for (int i = 0; i < 4; i++) begin
            e[i*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
        end
        return e;
    endfunction

    typedef struct {
        logic [15:0] sw;
        bit          exp_valid;
        bit          exp_error;
        logic [15:0] exp_guess;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int n, valids, seg_left;
        bit found, any_busy;

        vecs[0]  = '{16'h1234, 1'b1, 1'b0, 16'h1234};
        vecs[1]  = '{16'h9876, 1'b1, 1'b0, 16'h9876};
        vecs[2]  = '{16'h12A4, 1'b0, 1'b1, 16'h9876};
        vecs[3]  = '{16'h1123, !DISTINCT, DISTINCT, DISTINCT ? 16'h9876 : 16'h1123};
        vecs[4]  = '{16'h0987, 1'b1, 1'b0, 16'h0987};
        vecs[5]  = '{16'hF000, 1'b0, 1'b1, 16'h0987};
        vecs[6]  = '{16'h9990, !DISTINCT, DISTINCT, DISTINCT ? 16'h0987 : 16'h9990};
        vecs[7]  = '{16'h0129, 1'b1, 1'b0, 16'h0129};
        vecs[8]  = '{16'h0A00, 1'b0, 1'b1, 16'h0129};
        vecs[9]  = '{16'h5555, !DISTINCT, DISTINCT, DISTINCT ? 16'h0129 : 16'h5555};
        vecs[10] = '{16'h3021, 1'b1, 1'b0, 16'h3021};

        // Reset state
        reset = 1;
        repeat (3) step();
        check("reset_outputs", 32'({guess_valid, guess_error, busy, guess}), 32'h0);
        reset = 0;
        repeat (4) step();

        // Clean press: exact latency of busy and guess_valid
        guess_ready = 1;
        SW = 16'h1234;
        confirma = 1;
        repeat (6) step();
        check("clean_busy_before_check", 32'(busy), 32'h0);
        step();
        check("clean_busy_check", 32'(busy), 32'h1);
        check("clean_valid_not_yet", 32'(guess_valid), 32'h0);
        step();
        check("clean_valid", 32'(guess_valid), 32'h1);
        check("clean_guess", 32'(guess), 32'h1234);
        check("clean_busy_offer", 32'(busy), 32'h1);
        step();
        check("clean_valid_drop", 32'(guess_valid), 32'h0);
        check("clean_busy_drop", 32'(busy), 32'h0);
        confirma = 0;
        repeat (12) step();

        // Vector table, ready held high
        for (int i = 0; i < 11; i++) begin
            SW = vecs[i].sw;
            confirma = 1;
            repeat (8) step();
            check($sformatf("vec%0d_valid", i), 32'(guess_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_error", i), 32'(guess_error), 32'(vecs[i].exp_error));
            step();
            check($sformatf("vec%0d_guess", i), 32'(guess), 32'(vecs[i].exp_guess));
            check($sformatf("vec%0d_error_one_cycle", i), 32'(guess_error), 32'h0);
            check($sformatf("vec%0d_idle", i), 32'({guess_valid, busy}), 32'h0);
            confirma = 0;
            repeat (12) step();
        end

        // Backpressure with switch change during the offer
        guess_ready = 0;
        SW = 16'h9876;
        confirma = 1;
        repeat (8) step();
        for (int i = 0; i < 10; i++) begin
            if (i == 4) SW = 16'h0000;
            step();
            check("bp_valid_held", 32'(guess_valid), 32'h1);
            check("bp_guess_held", 32'(guess), 32'h9876);
        end
        guess_ready = 1;
        step();
        check("bp_valid_drop", 32'(guess_valid), 32'h0);
        check("bp_guess_after", 32'(guess), 32'h9876);
        confirma = 0;
        repeat (12) step();

        // Bounce: three short pulses, then steady high
        SW = 16'h4567;
        any_busy = 0;
        for (int r = 0; r < 3; r++) begin
            confirma = 1;
            repeat (3) begin step(); any_busy |= busy; end
            confirma = 0;
            step(); any_busy |= busy;
        end
        check("bounce_no_press", 32'(any_busy), 32'h0);
        confirma = 1;
        found = 0;
        n = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            step();
            if (guess_valid) begin found = 1; n = k; end
        end
        check("bounce_latency", 32'(n), 32'd8);
        valids = found ? 1 : 0;
        repeat (12) begin step(); if (guess_valid) valids++; end
        check("bounce_single_valid", 32'(valids), 32'd1);
        confirma = 0;
        repeat (12) step();

        // Reset while offering
        guess_ready = 0;
        SW = 16'h2468;
        confirma = 1;
        repeat (8) step();
        check("rst_offer_valid", 32'(guess_valid), 32'h1);
        reset = 1;
        confirma = 0;
        step();
        reset = 0;
        check("rst_offer_outputs", 32'({guess_valid, guess_error, busy, guess}), 32'h0);
        repeat (12) begin step(); if (guess_valid) check("rst_no_reoffer", 32'(guess_valid), 32'h0); end
        guess_ready = 1;
        SW = 16'h1357;
        confirma = 1;
        repeat (8) step();
        check("rst_new_valid", 32'(guess_valid), 32'h1);
        check("rst_new_guess", 32'(guess), 32'h1357);
        step();
        check("rst_new_drop", 32'(guess_valid), 32'h0);
        confirma = 0;
        repeat (12) step();

        // Randomized phase against the reference model
        seg_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (seg_left == 0) begin
                confirma = ~confirma;
                seg_left = $urandom_range(1, 12);
            end
            seg_left--;
            if ($urandom_range(0, 4) == 0) SW = rand_entry();
            guess_ready = ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 249) == 0);
            step();
        end
        reset = 0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
